// File: rtl/axis_packet_arbiter_if.sv
// Bundle of source-side, FIFO-side and status signals for the packet arbiter.
// master = arbiter side, slave = environment (producers, FIFO, observers).
interface axis_packet_arbiter_if #(
  parameter int NUM_SOURCES = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int IDX_W       = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
);
  // Handshake: a beat moves on any rising edge where tvalid and tready are
  // both high; tvalid never waits on tready, tready may depend on tvalid.
  logic [NUM_SOURCES*DATA_WIDTH-1:0] inData;
  logic [NUM_SOURCES-1:0]            inTValid;
  logic [NUM_SOURCES-1:0]            inTReady;
  logic [NUM_SOURCES-1:0]            inTLast;
  logic [NUM_SOURCES*4-1:0]          inTStrb;
  logic [DATA_WIDTH-1:0]             outData;
  logic                              outTValid;
  logic                              outTReady;
  logic                              outTLast;
  logic [3:0]                        outTStrb;
  logic                              grantValid;
  logic [IDX_W-1:0]                  grantIndex;
  logic                              packetTruncated;
  logic                              dbgState;

  modport master (
    input  inData, inTValid, inTLast, inTStrb, outTReady,
    output inTReady, outData, outTValid, outTLast, outTStrb,
           grantValid, grantIndex, packetTruncated, dbgState
  );

  modport slave (
    output inData, inTValid, inTLast, inTStrb, outTReady,
    input  inTReady, outData, outTValid, outTLast, outTStrb,
           grantValid, grantIndex, packetTruncated, dbgState
  );
endinterface

// File: rtl/axis_packet_arbiter.sv
// Packet-aware round-robin arbiter feeding one AXI-Stream FIFO input.
// Grant is held until TLAST is accepted; a beat watchdog forces TLAST.
module axis_packet_arbiter #(
  parameter int NUM_SOURCES      = 4,
  parameter int DATA_WIDTH       = 32,
  parameter int MAX_PACKET_BEATS = 256
) (
  input logic                    clock,
  input logic                    reset,
  axis_packet_arbiter_if.master  bus
);
  localparam int IW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam int CW = $clog2(MAX_PACKET_BEATS + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_PACKET_BEATS - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_last_grant;
  logic [IW-1:0]   r_grant;
  logic [CW-1:0]   r_beat_count;
  logic            r_truncated;

  logic [IW-1:0]   w_winner;
  int              w_best_dist;
  int              w_dist;
  logic            w_any_valid;
  logic            w_busy;
  logic            w_src_valid;
  logic            w_src_last;
  logic            w_out_valid;
  logic            w_out_last;
  logic            w_accept;

  assign w_busy = (r_state == BUSY);

  // Winner is the valid source at the smallest rotational distance past lastGrant.
  always_comb begin
    w_winner    = r_last_grant;
    w_best_dist = NUM_SOURCES;
    w_dist      = 0;
    w_any_valid = |bus.inTValid;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      w_dist = (i + NUM_SOURCES - 1 - int'(r_last_grant)) % NUM_SOURCES;
      if (bus.inTValid[i] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        w_winner    = IW'(i);
      end
    end
  end

  always_comb begin
    bus.inTReady = '0;
    bus.outData  = '0;
    bus.outTStrb = '0;
    w_src_valid  = 1'b0;
    w_src_last   = 1'b0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (w_busy && (r_grant == IW'(i))) begin
        bus.outData     = bus.inData[i*DATA_WIDTH +: DATA_WIDTH];
        bus.outTStrb    = bus.inTStrb[i*4 +: 4];
        w_src_valid     = bus.inTValid[i];
        w_src_last      = bus.inTLast[i];
        bus.inTReady[i] = bus.outTReady & ~reset;
      end
    end
  end

  assign w_out_valid   = w_busy & w_src_valid & ~reset;
  assign w_out_last    = w_src_last | (r_beat_count == LAST_BEAT);
  assign w_accept      = w_out_valid & bus.outTReady;
  assign bus.outTValid = w_out_valid;
  assign bus.outTLast  = w_busy & w_out_last;

  assign bus.grantValid      = w_busy;
  assign bus.grantIndex      = r_grant;
  assign bus.packetTruncated = r_truncated;
  assign bus.dbgState        = r_state;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= IW'(NUM_SOURCES - 1);
      r_grant      <= '0;
      r_beat_count <= '0;
      r_truncated  <= 1'b0;
    end else begin
      r_truncated <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_valid) begin
            r_grant      <= w_winner;
            r_beat_count <= '0;
            r_state      <= BUSY;
          end
        end
        BUSY: begin
          if (w_accept) begin
            if (w_out_last) begin
              r_last_grant <= r_grant;
              r_beat_count <= '0;
              r_state      <= IDLE;
              // Watchdog end: the source itself did not mark this beat last.
              r_truncated  <= ~w_src_last;
            end else begin
              r_beat_count <= r_beat_count + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Bench for axis_packet_arbiter: directed scenarios plus randomized packets,
// checked against a round-robin packet model built from per-source queues.
module tb_axis_packet_arbiter;
  localparam int NUM  = 4;
  localparam int DW   = 32;
  localparam int MAXB = 4;
  localparam int EW   = 2 + 1 + 1 + 4 + DW;

  typedef struct packed {
    logic          last;
    logic [3:0]    strb;
    logic [DW-1:0] data;
  } beat_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  axis_packet_arbiter_if #(.NUM_SOURCES(NUM), .DATA_WIDTH(DW)) bus();

  axis_packet_arbiter #(
    .NUM_SOURCES(NUM), .DATA_WIDTH(DW), .MAX_PACKET_BEATS(MAXB)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  beat_t         src_q[NUM][$];
  logic [EW-1:0] exp_q[$];
  int            acc_cyc[$];
  int            acc_g[$];
  logic          acc_last[$];
  logic          gv_hist[$];
  int            gi_hist[$];

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   ready_mode = 0;
  int   pat_idx  = 0;
  int   pat[4]   = '{1, 0, 0, 1};
  int   trunc_err = 0;
  int   proto_err = 0;
  int   trunc_seen = 0;
  int   trunc_exp_total = 0;
  logic forced_pending = 1'b0;

  // ---------------- reference model ----------------
  // Round robin over sources with pending beats; a packet ends at the
  // source's last flag or at the MAXB-th beat, whichever comes first.
  function automatic void build_model(input int lg);
    beat_t m[NUM][$];
    beat_t b;
    int    last_g, g, n;
    logic  ol, fc;
    for (int i = 0; i < NUM; i++) m[i] = src_q[i];
    last_g = lg;
    while (1) begin
      g = -1;
      for (int k = 1; k <= NUM; k++)
        if (g < 0 && m[(last_g + k) % NUM].size() > 0) g = (last_g + k) % NUM;
      if (g < 0) break;
      n  = 0;
      ol = 1'b0;
      while (!ol && m[g].size() > 0) begin
        b  = m[g].pop_front();
        n++;
        ol = b.last || (n == MAXB);
        fc = ol && !b.last;
        exp_q.push_back({2'(g), fc, ol, b.strb, b.data});
        trunc_exp_total += int'(fc);
      end
      last_g = g;
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_sources();
    beat_t b;
    for (int i = 0; i < NUM; i++) begin
      if (src_q[i].size() > 0) begin
        b = src_q[i][0];
        bus.inTValid[i]           = 1'b1;
        bus.inData[i*DW +: DW]    = b.data;
        bus.inTStrb[i*4 +: 4]     = b.strb;
        bus.inTLast[i]            = b.last;
      end else begin
        bus.inTValid[i]           = 1'b0;
        bus.inData[i*DW +: DW]    = '0;
        bus.inTStrb[i*4 +: 4]     = '0;
        bus.inTLast[i]            = 1'b0;
      end
    end
  endtask

  task automatic next_ready();
    case (ready_mode)
      1:       bus.outTReady = 1'($urandom_range(0, 1));
      2:       begin bus.outTReady = 1'(pat[pat_idx % 4]); pat_idx++; end
      default: bus.outTReady = 1'b1;
    endcase
  endtask

  task automatic load_packet(input int src, input int len, input int last_at, input int tag);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = DW'(tag + k);
      b.strb = 4'($urandom_range(1, 15));
      b.last = (k == last_at);
      src_q[src].push_back(b);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    for (int i = 0; i < NUM; i++) src_q[i].delete();
    exp_q.delete();
    drive_sources();
    bus.outTReady = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    forced_pending = 1'b0;
    trunc_err = 0; proto_err = 0; trunc_seen = 0; trunc_exp_total = 0;
    acc_cyc.delete(); acc_g.delete(); acc_last.delete();
    gv_hist.delete(); gi_hist.delete();
    cyc = 0;
  endtask

  // One clock: observe at negedge, advance sources and ready after posedge.
  task automatic step();
    logic [NUM-1:0] acc_src;
    logic [NUM-1:0] exp_rdy;
    logic [EW-1:0]  e;
    @(negedge clock);
    gv_hist.push_back(bus.grantValid);
    gi_hist.push_back(int'(bus.grantIndex));
    exp_rdy = bus.grantValid ? (NUM'(bus.outTReady) << bus.grantIndex) : '0;
    if (bus.inTReady !== exp_rdy || (!bus.grantValid && bus.outTValid)) proto_err++;
    if (bus.packetTruncated !== forced_pending) trunc_err++;
    if (bus.packetTruncated === 1'b1) trunc_seen++;
    forced_pending = 1'b0;
    acc_src = bus.inTValid & bus.inTReady;
    if (bus.outTValid && bus.outTReady) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL beat_extra: got g=%0d data=%h, expected no beat", bus.grantIndex, bus.outData);
      end else begin
        e = exp_q.pop_front();
        forced_pending = e[DW+5];
        if ({bus.grantIndex, bus.outTLast, bus.outTStrb, bus.outData} !== {e[DW+7:DW+6], e[DW+4:0]})
          $display("FAIL beat: got g=%0d last=%b strb=%h data=%h, expected g=%0d last=%b strb=%h data=%h",
                   bus.grantIndex, bus.outTLast, bus.outTStrb, bus.outData,
                   e[DW+7:DW+6], e[DW+4], e[DW+3:DW], e[DW-1:0]);
        else n_pass++;
      end
      acc_cyc.push_back(cyc);
      acc_g.push_back(int'(bus.grantIndex));
      acc_last.push_back(bus.outTLast);
    end
    @(posedge clock); #1;
    cyc++;
    for (int i = 0; i < NUM; i++) if (acc_src[i]) void'(src_q[i].pop_front());
    drive_sources();
    next_ready();
  endtask

  task automatic drain(input int budget, input string name);
    int b = 0;
    while (exp_q.size() > 0 && b < budget) begin step(); b++; end
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL %s_drain: %0d beats still expected after %0d cycles, required 0", name, exp_q.size(), budget);
    else n_pass++;
    repeat (3) step();
    n_checks++;
    if (trunc_err != 0 || proto_err != 0)
      $display("FAIL %s_protocol: trunc_err=%0d proto_err=%0d, required 0/0", name, trunc_err, proto_err);
    else n_pass++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    @(negedge clock);
    n_checks++;
    if ({bus.grantValid, bus.grantIndex, bus.packetTruncated, bus.outTValid, bus.inTReady} !== '0)
      $display("FAIL reset_state: got gv=%b gi=%0d pt=%b ov=%b ir=%b, required all 0",
               bus.grantValid, bus.grantIndex, bus.packetTruncated, bus.outTValid, bus.inTReady);
    else n_pass++;
    n_checks++;
    if (bus.dbgState !== 1'b0) $display("FAIL reset_dbg_state: got %b, required 0", bus.dbgState);
    else n_pass++;
    @(posedge clock); #1;
  endtask

  task automatic test_single_packet();
    apply_reset();
    ready_mode = 0;
    load_packet(0, 3, 2, 32'hA0);
    build_model(NUM - 1);
    drive_sources();
    drain(20, "single");
    n_checks++;
    if (acc_cyc.size() != 3 || acc_cyc[0] != 1 || acc_cyc[1] != 2 || acc_cyc[2] != 3)
      $display("FAIL single_timing: got %0d beats first at cycle %0d, required 3 beats at cycles 1..3",
               acc_cyc.size(), (acc_cyc.size() > 0) ? acc_cyc[0] : -1);
    else n_pass++;
    n_checks++;
    if (gv_hist[0] !== 1'b0 || gv_hist[1] !== 1'b1 || gv_hist[4] !== 1'b0)
      $display("FAIL single_grant_window: got gv c0=%b c1=%b c4=%b, required 0 1 0",
               gv_hist[0], gv_hist[1], gv_hist[4]);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int starts[$];
    int order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int bad_gap = 0;
    apply_reset();
    ready_mode = 0;
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < NUM; s++) load_packet(s, 2, 1, (s << 12) | (p << 8));
    build_model(NUM - 1);
    drive_sources();
    drain(100, "rr");
    for (int k = 0; k < acc_g.size(); k++) begin
      if (k == 0 || acc_last[k-1]) begin
        starts.push_back(acc_g[k]);
        if (k > 0 && acc_cyc[k] - acc_cyc[k-1] != 2) bad_gap++;
      end
    end
    n_checks++;
    if (starts.size() != 8) $display("FAIL rr_packet_count: got %0d, required 8", starts.size());
    else n_pass++;
    for (int k = 0; k < 8 && k < starts.size(); k++) begin
      n_checks++;
      if (starts[k] != order[k]) $display("FAIL rr_order[%0d]: got %0d, required %0d", k, starts[k], order[k]);
      else n_pass++;
    end
    n_checks++;
    if (bad_gap != 0) $display("FAIL rr_bubble: got %0d gaps not equal to 2 cycles, required 0", bad_gap);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int held_bad = 0;
    apply_reset();
    ready_mode = 2;
    pat_idx = 0;
    next_ready();
    load_packet(1, 4, 3, 32'h1100);
    load_packet(2, 2, 1, 32'h2200);
    build_model(NUM - 1);
    drive_sources();
    drain(60, "bp");
    if (acc_cyc.size() >= 4)
      for (int c = acc_cyc[0]; c <= acc_cyc[3]; c++)
        if (gv_hist[c] !== 1'b1 || gi_hist[c] != 1) held_bad++;
    n_checks++;
    if (acc_cyc.size() != 6 || held_bad != 0)
      $display("FAIL bp_grant_held: got %0d beats, %0d cycles off-grant, required 6 and 0", acc_cyc.size(), held_bad);
    else n_pass++;
    ready_mode = 0;
  endtask

  task automatic test_truncation();
    logic [5:0] lasts = '0;
    apply_reset();
    ready_mode = 0;
    load_packet(3, 6, 5, 32'h3300);
    build_model(NUM - 1);
    drive_sources();
    drain(40, "trunc");
    for (int k = 0; k < 6 && k < acc_last.size(); k++) lasts[k] = acc_last[k];
    n_checks++;
    if (acc_last.size() != 6 || lasts !== 6'b101000)
      $display("FAIL trunc_lasts: got %0d beats lasts=%b, required 6 beats lasts=101000", acc_last.size(), lasts);
    else n_pass++;
    n_checks++;
    if (trunc_seen != 1) $display("FAIL trunc_pulses: got %0d, required 1", trunc_seen);
    else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    int b = 0;
    apply_reset();
    ready_mode = 0;
    load_packet(2, 5, 4, 32'h5500);
    build_model(NUM - 1);
    drive_sources();
    while (acc_cyc.size() < 1 && b < 10) begin step(); b++; end
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if (bus.inTReady !== '0 || bus.outTValid !== 1'b0)
      $display("FAIL midreset_gate: got inTReady=%b outTValid=%b, required 0000 and 0", bus.inTReady, bus.outTValid);
    else n_pass++;
    @(posedge clock); #1;
    reset = 1'b0;
    cyc++;
    forced_pending = 1'b0;
    exp_q.delete();
    acc_cyc.delete(); acc_g.delete(); acc_last.delete();
    n_checks++;
    if (src_q[2].size() != 4) $display("FAIL midreset_beats_taken: got %0d left, required 4", src_q[2].size());
    else n_pass++;
    load_packet(0, 2, 1, 32'h0500);
    build_model(NUM - 1);
    drive_sources();
    drain(40, "midreset");
    n_checks++;
    if (acc_g.size() == 0 || acc_g[0] != 0)
      $display("FAIL midreset_next_grant: got %0d, required 0", (acc_g.size() > 0) ? acc_g[0] : -1);
    else n_pass++;
  endtask

  task automatic test_single_source_regrant();
    int not_two = 0;
    apply_reset();
    ready_mode = 0;
    load_packet(2, 3, 2, 32'h6600);
    load_packet(2, 1, 0, 32'h6700);
    build_model(NUM - 1);
    drive_sources();
    drain(30, "regrant");
    foreach (acc_g[k]) if (acc_g[k] != 2) not_two++;
    n_checks++;
    if (acc_g.size() != 4 || not_two != 0)
      $display("FAIL regrant_source: got %0d beats, %0d from other sources, required 4 and 0", acc_g.size(), not_two);
    else n_pass++;
    n_checks++;
    if (acc_cyc.size() != 4 || acc_cyc[3] - acc_cyc[2] != 2)
      $display("FAIL regrant_bubble: got gap %0d, required 2",
               (acc_cyc.size() == 4) ? acc_cyc[3] - acc_cyc[2] : -1);
    else n_pass++;
  endtask

  task automatic test_random();
    int npk, len, last_at;
    for (int r = 0; r < 6; r++) begin
      apply_reset();
      ready_mode = 1;
      for (int s = 0; s < NUM; s++) begin
        npk = $urandom_range(0, 3);
        for (int p = 0; p < npk; p++) begin
          len = $urandom_range(1, 6);
          last_at = len - 1;
          load_packet(s, len, last_at, int'($urandom) & 32'hFFFF_F000);
        end
      end
      build_model(NUM - 1);
      drive_sources();
      next_ready();
      drain(2000, "random");
      n_checks++;
      if (trunc_seen != trunc_exp_total)
        $display("FAIL random_trunc_count[%0d]: got %0d, required %0d", r, trunc_seen, trunc_exp_total);
      else n_pass++;
    end
    ready_mode = 0;
  endtask

  initial begin
    bus.inTValid  = '0;
    bus.inTLast   = '0;
    bus.inData    = '0;
    bus.inTStrb   = '0;
    bus.outTReady = 1'b1;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_truncation();
    test_reset_mid_packet();
    test_single_source_regrant();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end
endmodule
